// File: rtl/fdiv_sched_pkg.sv
// Shared types and constants for the fp16 divider scheduler.
package fdiv_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam int          FP16_W    = 16;
   localparam logic [15:0] FP16_QNAN = 16'h7E00;

   // Round-robin pointer advance: the slot after the winner, wrapping at n.
   function automatic int rr_next(input int g, input int n);
      if (g + 1 >= n) begin
         return 0;
      end else begin
         return g + 1;
      end
   endfunction

endpackage

// File: rtl/fdiv_sched_if.sv
// Requester, response and divider signals of the scheduler.
// master = requesters/divider side, slave = scheduler side.
interface fdiv_sched_if #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) ();
   logic [NREQ-1:0]    req_valid;
   logic [NREQ*16-1:0] req_f1;
   logic [NREQ*16-1:0] req_f2;
   logic [NREQ-1:0]    req_ready;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [IDW-1:0]     rsp_id;
   logic [15:0]        rsp_f;
   logic               rsp_err;
   logic               div_reset;
   logic               div_enable;
   logic [15:0]        div_f1;
   logic [15:0]        div_f2;
   logic               div_done;
   logic [15:0]        div_f;

   modport master (
      output req_valid, req_f1, req_f2, rsp_ready, div_done, div_f,
      input  req_ready, rsp_valid, rsp_id, rsp_f, rsp_err,
             div_reset, div_enable, div_f1, div_f2
   );

   modport slave (
      input  req_valid, req_f1, req_f2, rsp_ready, div_done, div_f,
      output req_ready, rsp_valid, rsp_id, rsp_f, rsp_err,
             div_reset, div_enable, div_f1, div_f2
   );
endinterface

// File: rtl/fdiv_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above ptr, wrapping.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  gid
);
   logic found_s;
   int   idx_s;

   // Scan NREQ slots starting at ptr; the first hit wins.
   always_comb begin
      grant   = '0;
      gid     = '0;
      found_s = 1'b0;
      idx_s   = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx_s = int'(ptr) + k;
         if (idx_s >= NREQ) begin
            idx_s = idx_s - NREQ;
         end else begin
            idx_s = idx_s;
         end
         if (!found_s && req[idx_s]) begin
            grant[idx_s] = 1'b1;
            gid          = IDW'(idx_s);
            found_s      = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end
endmodule

// File: rtl/fdiv_sched.sv
// Round-robin scheduler sharing one fp16 divider among NREQ requesters.
// Optional WAIT watchdog enabled by defining FDIV_SCHED_TIMEOUT_EN.
module fdiv_sched
   import fdiv_sched_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int IDW     = $clog2(NREQ),
   parameter int TIMEOUT = 64
) (
   input logic         clk,
   input logic         reset_n,
   fdiv_sched_if.slave bus
);
   state_t            state_r, state_nxt_s;
   logic [IDW-1:0]    ptr_r, gid_s, rsp_id_r;
   logic [NREQ-1:0]   grant_s, req_ready_s;
   logic [FP16_W-1:0] div_f1_r, div_f2_r, rsp_f_r;
   logic              accept_s, done_s, timeout_s;
   logic              div_reset_s, div_enable_s, rsp_valid_s;

   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
      .req   (bus.req_valid),
      .ptr   (ptr_r),
      .grant (grant_s),
      .gid   (gid_s)
   );

   assign accept_s = (state_r == IDLE) & (|bus.req_valid);
   assign done_s   = (state_r == WAIT) & bus.div_done;

`ifdef FDIV_SCHED_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT) + 1;
   logic [CW-1:0] cnt_r;
   logic          rsp_err_r;

   // done on the expiry cycle takes priority over the watchdog
   assign timeout_s = (state_r == WAIT) & ~bus.div_done & (cnt_r == CW'(TIMEOUT - 1));

   // Watchdog counter: cleared in START so it reads 0 on the first WAIT cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_r <= '0;
      end else if (state_r == START) begin
         cnt_r <= '0;
      end else if (state_r == WAIT) begin
         cnt_r <= cnt_r + 1'b1;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // Error flag accompanies the quotient latched at the end of WAIT.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsp_err_r <= 1'b0;
      end else if (done_s) begin
         rsp_err_r <= 1'b0;
      end else if (timeout_s) begin
         rsp_err_r <= 1'b1;
      end else begin
         rsp_err_r <= rsp_err_r;
      end
   end

   assign bus.rsp_err = rsp_err_r;
`else
   assign timeout_s   = 1'b0;
   assign bus.rsp_err = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE:    state_nxt_s = accept_s ? START : IDLE;
         START:   state_nxt_s = WAIT;
         WAIT:    state_nxt_s = (bus.div_done || timeout_s) ? RESP : WAIT;
         RESP:    state_nxt_s = bus.rsp_ready ? IDLE : RESP;
         default: state_nxt_s = IDLE;
      endcase
   end

   // State-decoded handshake and divider controls.
   always_comb begin
      req_ready_s  = '0;
      div_reset_s  = 1'b1;
      div_enable_s = 1'b0;
      rsp_valid_s  = 1'b0;
      case (state_r)
         IDLE:  req_ready_s = grant_s;
         START: begin
            div_reset_s  = 1'b0;
            div_enable_s = 1'b1;
         end
         WAIT:  div_reset_s = 1'b0;
         RESP:  rsp_valid_s = 1'b1;
         default: begin
            req_ready_s  = '0;
            div_reset_s  = 1'b1;
            div_enable_s = 1'b0;
            rsp_valid_s  = 1'b0;
         end
      endcase
   end

   // Operands and id are captured only on accept, so they hold until the next job.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr_r    <= '0;
         div_f1_r <= '0;
         div_f2_r <= '0;
         rsp_id_r <= '0;
      end else if (accept_s) begin
         ptr_r    <= IDW'(rr_next(int'(gid_s), NREQ));
         div_f1_r <= bus.req_f1[int'(gid_s)*FP16_W +: FP16_W];
         div_f2_r <= bus.req_f2[int'(gid_s)*FP16_W +: FP16_W];
         rsp_id_r <= gid_s;
      end else begin
         ptr_r    <= ptr_r;
         div_f1_r <= div_f1_r;
         div_f2_r <= div_f2_r;
         rsp_id_r <= rsp_id_r;
      end
   end

   // Quotient capture at the end of WAIT.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsp_f_r <= '0;
      end else if (done_s) begin
         rsp_f_r <= bus.div_f;
      end else if (timeout_s) begin
         rsp_f_r <= FP16_QNAN;
      end else begin
         rsp_f_r <= rsp_f_r;
      end
   end

   assign bus.req_ready  = req_ready_s;
   assign bus.div_reset  = div_reset_s;
   assign bus.div_enable = div_enable_s;
   assign bus.rsp_valid  = rsp_valid_s;
   assign bus.div_f1     = div_f1_r;
   assign bus.div_f2     = div_f2_r;
   assign bus.rsp_id     = rsp_id_r;
   assign bus.rsp_f      = rsp_f_r;
endmodule
